// File: rtl/mod_mac_accum.sv
// mod_mac_accum: modular multiply-accumulate back end for the Montgomery multiplier.
// Ports: clk, rst (async active-low); tag_valid/tag_last (operand tag),
//   prod_in (multiplier P_out); out_data/out_terms/out_valid/out_ready
//   (result handshake); overrun (sticky drop flag); busy (burst or tags in flight).
module mod_mac_accum #(
    parameter int data_width = 256,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16,
    parameter logic [data_width-1:0] M =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tag_valid,
    input  logic                  tag_last,
    input  logic [data_width-1:0] prod_in,
    output logic [data_width-1:0] out_data,
    output logic [CNT_W-1:0]      out_terms,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  busy
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state_q, state_d;
    logic [MUL_LAT-1:0]    vld_q, vld_d;
    logic [MUL_LAT-1:0]    lst_q, lst_d;
    logic [data_width-1:0] acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [data_width-1:0] out_data_q;
    logic [CNT_W-1:0]      out_terms_q;
    logic                  out_valid_q;
    logic                  overrun_q;
    logic                  busy_q;

    logic                  a_valid, a_last, first;
    logic                  done, load;
    logic [data_width-1:0] base;
    logic [data_width:0]   sum_w;
    logic [data_width-1:0] red;
    logic [CNT_W-1:0]      cnt_nxt;

    // Tag delay line; tag_last only travels with a valid tag.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = tag_valid;
        lst_d    = lst_q << 1;
        lst_d[0] = tag_valid & tag_last;
    end

    assign a_valid = vld_q[MUL_LAT-1];
    assign a_last  = lst_q[MUL_LAT-1];
    assign first   = (state_q == IDLE);

    // Both addends are < M, so a single conditional subtract reduces the sum.
    always_comb begin
        base  = first ? '0 : acc_q;
        sum_w = {1'b0, base} + {1'b0, prod_in};
        if (sum_w >= {1'b0, M})
            red = sum_w[data_width-1:0] - M;
        else
            red = sum_w[data_width-1:0];
    end

    always_comb begin
        if (first)
            cnt_nxt = CNT_W'(1);
        else if (&cnt_q)
            cnt_nxt = cnt_q;
        else
            cnt_nxt = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        if (a_valid)
            state_d = a_last ? IDLE : ACCUM;
    end

    assign done = a_valid & a_last;
    assign load = done & (~out_valid_q | out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            lst_q       <= '0;
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_terms_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            lst_q   <= lst_d;
            state_q <= state_d;
            busy_q  <= (state_d == ACCUM) | (|vld_d);
            // acc/cnt stay stale after a burst; IDLE restarts the next one.
            if (a_valid) begin
                acc_q <= red;
                cnt_q <= cnt_nxt;
            end
            if (load) begin
                out_data_q  <= red;
                out_terms_q <= cnt_nxt;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Completed burst with an unconsumed result: drop it.
            if (done && !load)
                overrun_q <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_terms = out_terms_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mod_mac_accum.sv
// tb_mod_mac_accum: directed bench for mod_mac_accum with a burst-level model.
// Ports: none (drives clk, rst and the tag/product/handshake inputs).
module tb_mod_mac_accum;

    localparam logic [255:0] MOD =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tag_valid = 1'b0;
    logic         tag_last = 1'b0;
    logic [255:0] prod_in = '0;
    logic [255:0] out_data;
    logic [15:0]  out_terms;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         overrun;
    logic         busy;

    mod_mac_accum dut (
        .clk(clk), .rst(rst),
        .tag_valid(tag_valid), .tag_last(tag_last),
        .prod_in(prod_in),
        .out_data(out_data), .out_terms(out_terms),
        .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           last;
        logic [255:0] p;
    } tag_t;

    tag_t         hist [int];
    logic [271:0] cap_q [$];
    int           cyc = 0;
    int           vecs = 0;
    int           errs = 0;
    bit           chk_en = 0;

    bit           m_first = 1;
    logic [255:0] m_acc = '0;
    int           m_cnt = 0;
    bit           m_valid = 0;
    logic [255:0] m_data = '0;
    int           m_terms = 0;
    bit           m_ovr = 0;

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mod_add(logic [255:0] a, logic [255:0] b);
        logic [511:0] w;
        logic [511:0] r;
        w = {256'b0, a} + {256'b0, b};
        r = w % {256'b0, MOD};
        return r[255:0];
    endfunction

    task automatic model_reset();
        m_first = 1; m_acc = '0; m_cnt = 0;
        m_valid = 0; m_data = '0; m_terms = 0; m_ovr = 0;
        hist.delete();
    endtask

    // Effect of the edge that ends cycle cyc on the burst/result model.
    task automatic model_edge(bit rdy);
        bit           loaded;
        tag_t         t;
        logic [255:0] s;
        int           n;
        loaded = 0;
        if (hist.exists(cyc - LAT)) begin
            t = hist[cyc - LAT];
            s = mod_add(m_first ? 256'd0 : m_acc, t.p);
            n = m_first ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1);
            m_acc = s; m_cnt = n; m_first = t.last;
            if (t.last) begin
                if (!m_valid || rdy) begin
                    m_valid = 1; m_data = s; m_terms = n; loaded = 1;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        if (!loaded && rdy) m_valid = 0;
    endtask

    task automatic step(bit tv, bit tl, bit rdy, logic [255:0] p);
        tag_t t;
        tag_valid = tv; tag_last = tl; out_ready = rdy;
        if (tv) begin
            t.last = tl; t.p = p; hist[cyc] = t;
        end
        if (hist.exists(cyc - LAT)) prod_in = hist[cyc - LAT].p;
        else prod_in = 256'h5a5a;
        @(posedge clk);
        model_edge(rdy);
        cyc++;
        #1;
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) step(1'b0, 1'b1, rdy, '0);
    endtask

    task automatic expect_cap(string nm, logic [255:0] d, logic [15:0] n);
        logic [271:0] c;
        if (cap_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL %s: got no result expected %0h/%0d", nm, d, n);
        end else begin
            c = cap_q.pop_front();
            chk({nm, "_data"}, c[255:0], d);
            chk({nm, "_terms"}, {240'b0, c[271:256]}, {240'b0, n});
        end
    endtask

    always @(negedge clk) begin
        bit bexp;
        if (chk_en && rst) begin
            bexp = !m_first;
            for (int k = 1; k <= LAT; k++)
                if (hist.exists(cyc - k)) bexp = 1;
            chk("out_valid", {255'b0, out_valid}, {255'b0, m_valid});
            chk("overrun", {255'b0, overrun}, {255'b0, m_ovr});
            chk("busy", {255'b0, busy}, {255'b0, bexp});
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_terms", {240'b0, out_terms}, 256'(m_terms));
            end
            if (out_valid && out_ready)
                cap_q.push_back({out_terms, out_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_data", out_data, 256'd0);
        chk("rst_terms", {240'b0, out_terms}, 256'd0);
        chk("rst_ovr", {255'b0, overrun}, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        rst = 1'b1;
        chk_en = 1;

        // Single term: result appears after the 4th edge.
        step(1, 1, 0, 256'd5);
        idle(2, 0);
        chk("t1_early", {255'b0, out_valid}, 256'd0);
        idle(1, 0);
        chk("t1_valid", {255'b0, out_valid}, 256'd1);
        chk("t1_data", out_data, 256'd5);
        chk("t1_terms", {240'b0, out_terms}, 256'd1);
        chk("t1_model", m_data, 256'd5);
        step(0, 1, 1, '0);
        expect_cap("t1", 256'd5, 16'd1);

        // Four terms, single output pulse.
        step(1, 0, 1, 256'd1);
        step(1, 0, 1, 256'd2);
        step(1, 0, 1, 256'd3);
        step(1, 1, 1, 256'd4);
        idle(5, 1);
        expect_cap("t2", 256'd10, 16'd4);
        chk("t2_pulses", 256'(cap_q.size()), 256'd0);

        // Modular wrap-around.
        step(1, 0, 1, MOD - 256'd1);
        step(1, 1, 1, 256'd2);
        idle(5, 1);
        expect_cap("t3a", 256'd1, 16'd2);
        step(1, 0, 1, MOD - 256'd1);
        step(1, 1, 1, 256'd1);
        idle(5, 1);
        expect_cap("t3b", 256'd0, 16'd2);

        // Back-pressure and sticky overrun.
        step(1, 1, 0, 256'd7);
        step(1, 1, 0, 256'd9);
        idle(5, 0);
        chk("t4_data", out_data, 256'd7);
        chk("t4_terms", {240'b0, out_terms}, 256'd1);
        chk("t4_ovr", {255'b0, overrun}, 256'd1);
        chk("t4_model_ovr", {255'b0, m_ovr}, 256'd1);
        step(0, 1, 1, '0);
        chk("t4_drain", {255'b0, out_valid}, 256'd0);
        chk("t4_ovr_hold", {255'b0, overrun}, 256'd1);
        expect_cap("t4", 256'd7, 16'd1);

        // Back-to-back bursts without a gap.
        step(1, 0, 1, 256'd1);
        step(1, 1, 1, 256'd1);
        step(1, 1, 1, 256'd2);
        idle(6, 1);
        expect_cap("t5a", 256'd2, 16'd2);
        expect_cap("t5b", 256'd2, 16'd1);

        // Asynchronous reset with terms in flight.
        step(1, 0, 1, 256'd3);
        step(1, 0, 1, 256'd4);
        #1;
        tag_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t6_valid", {255'b0, out_valid}, 256'd0);
        chk("t6_data", out_data, 256'd0);
        chk("t6_terms", {240'b0, out_terms}, 256'd0);
        chk("t6_ovr", {255'b0, overrun}, 256'd0);
        chk("t6_busy", {255'b0, busy}, 256'd0);
        @(posedge clk);
        cyc++;
        #2;
        rst = 1'b1;
        step(1, 1, 1, 256'd3);
        idle(5, 1);
        expect_cap("t6", 256'd3, 16'd1);
        chk("t6_left", 256'(cap_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
